// File: rtl/fft_result_unloader_pkg.sv
// Shared constants, read-side state encoding and index helper for the FFT result unloader.
package fft_result_unloader_pkg;

   localparam int   INST_WIDTH    = 32;
   localparam int   DEF_FRAC_BITS = 8;
   localparam int   FRAME_LEN     = 8;
   localparam logic FUN_ENABLE    = 1'b1;
   localparam logic FUN_DISABLE   = 1'b0;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_e;

   function automatic logic [2:0] bitrev3(input logic [2:0] i_idx);
      return {i_idx[0], i_idx[1], i_idx[2]};
   endfunction

endpackage

// File: rtl/fft_round_shift.sv
// Round-half-up arithmetic right shift removing Q8 scaling, with optional extra /8 for IFFT.
module fft_round_shift
   import fft_result_unloader_pkg::*;
#(
   parameter int DATA_W    = INST_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS
) (
   input  logic signed [DATA_W-1:0] i_x,
   input  logic                     i_ifft,
   output logic signed [DATA_W-1:0] o_y
);

   localparam int                     NORM_SHIFT = FRAC_BITS + 3;
   localparam logic signed [DATA_W:0] RND_FFT    = (DATA_W+1)'(1) << (FRAC_BITS - 1);
   localparam logic signed [DATA_W:0] RND_IFFT   = (DATA_W+1)'(1) << (NORM_SHIFT - 1);

   logic signed [DATA_W:0] w_ext;
   logic signed [DATA_W:0] w_sum;
   logic signed [DATA_W:0] w_shifted;

   // One guard bit keeps the rounding add of the largest positive input from wrapping.
   always_comb begin
      w_ext     = {i_x[DATA_W-1], i_x};
      w_sum     = w_ext + (i_ifft ? RND_IFFT : RND_FFT);
      w_shifted = i_ifft ? (w_sum >>> NORM_SHIFT) : (w_sum >>> FRAC_BITS);
      o_y       = w_shifted[DATA_W-1:0];
   end

endmodule

// File: rtl/fft_result_unloader.sv
// Captures parallel 8-sample FFT frames into a ping-pong store and streams them out one beat per cycle.
module fft_result_unloader
   import fft_result_unloader_pkg::*;
#(
   parameter int DATA_W    = INST_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter bit BITREV    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     butterfly3_ready,
   input  logic signed [DATA_W-1:0] fft_d1_real_o,
   input  logic signed [DATA_W-1:0] fft_d1_imag_o,
   input  logic signed [DATA_W-1:0] fft_d2_real_o,
   input  logic signed [DATA_W-1:0] fft_d2_imag_o,
   input  logic signed [DATA_W-1:0] fft_d3_real_o,
   input  logic signed [DATA_W-1:0] fft_d3_imag_o,
   input  logic signed [DATA_W-1:0] fft_d4_real_o,
   input  logic signed [DATA_W-1:0] fft_d4_imag_o,
   input  logic signed [DATA_W-1:0] fft_d5_real_o,
   input  logic signed [DATA_W-1:0] fft_d5_imag_o,
   input  logic signed [DATA_W-1:0] fft_d6_real_o,
   input  logic signed [DATA_W-1:0] fft_d6_imag_o,
   input  logic signed [DATA_W-1:0] fft_d7_real_o,
   input  logic signed [DATA_W-1:0] fft_d7_imag_o,
   input  logic signed [DATA_W-1:0] fft_d8_real_o,
   input  logic signed [DATA_W-1:0] fft_d8_imag_o,
   input  logic                     ifft_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_real,
   output logic signed [DATA_W-1:0] out_imag,
   output logic [2:0]               out_index,
   output logic                     out_last,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   logic signed [DATA_W-1:0] w_in_re [FRAME_LEN];
   logic signed [DATA_W-1:0] w_in_im [FRAME_LEN];

   assign w_in_re[0] = fft_d1_real_o;  assign w_in_im[0] = fft_d1_imag_o;
   assign w_in_re[1] = fft_d2_real_o;  assign w_in_im[1] = fft_d2_imag_o;
   assign w_in_re[2] = fft_d3_real_o;  assign w_in_im[2] = fft_d3_imag_o;
   assign w_in_re[3] = fft_d4_real_o;  assign w_in_im[3] = fft_d4_imag_o;
   assign w_in_re[4] = fft_d5_real_o;  assign w_in_im[4] = fft_d5_imag_o;
   assign w_in_re[5] = fft_d6_real_o;  assign w_in_im[5] = fft_d6_imag_o;
   assign w_in_re[6] = fft_d7_real_o;  assign w_in_im[6] = fft_d7_imag_o;
   assign w_in_re[7] = fft_d8_real_o;  assign w_in_im[7] = fft_d8_imag_o;

   logic signed [DATA_W-1:0] r_bank_re [2][FRAME_LEN];
   logic signed [DATA_W-1:0] r_bank_im [2][FRAME_LEN];
   logic [1:0]               r_full;
   logic [1:0]               r_mode;
   logic                     r_wr_bank;
   logic                     r_rd_bank;
   logic [2:0]               r_rd_idx;
   logic                     r_overflow;
   rd_state_e                r_state;
   rd_state_e                w_next_state;

   logic                     w_out_valid;
   logic                     w_pop;
   logic                     w_pop_last;
   logic                     w_accept;
   logic                     w_drop;
   logic                     w_other_ready;
   logic [2:0]               w_index;
   logic signed [DATA_W-1:0] w_y_re;
   logic signed [DATA_W-1:0] w_y_im;

   assign w_out_valid = (r_state == STREAM);
   assign w_pop       = w_out_valid & out_ready;
   assign w_pop_last  = w_pop & (r_rd_idx == 3'd7);
   // A bank being drained by its final pop this cycle may be refilled in the same cycle.
   assign w_accept    = butterfly3_ready
                        & (~r_full[r_wr_bank] | (w_pop_last & (r_rd_bank == r_wr_bank)));
   assign w_drop      = butterfly3_ready & ~w_accept;
   assign w_other_ready = r_full[~r_rd_bank] | (w_accept & (r_wr_bank != r_rd_bank));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (r_full[r_rd_bank] || (w_accept && (r_wr_bank == r_rd_bank)))
               w_next_state = STREAM;
         end
         STREAM: begin
            if (w_pop_last && !w_other_ready)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_full     <= 2'b00;
         r_mode     <= 2'b00;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_rd_idx   <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_pop)
            r_rd_idx <= r_rd_idx + 3'd1;
         if (w_pop_last) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
         end
         // NOTE: the later non-blocking set overrides the clear above when a freed bank is refilled.
         if (w_accept) begin
            r_full[r_wr_bank] <= 1'b1;
            r_mode[r_wr_bank] <= ifft_mode;
            r_wr_bank         <= ~r_wr_bank;
         end
         if (w_drop)
            r_overflow <= 1'b1;
         else if (overflow_clr)
            r_overflow <= 1'b0;
      end
   end

   // NOTE: sample storage has no reset; the full flags decide whether its contents are meaningful.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int k = 0; k < FRAME_LEN; k++) begin
            r_bank_re[r_wr_bank][k] <= w_in_re[k];
            r_bank_im[r_wr_bank][k] <= w_in_im[k];
         end
      end
   end

   assign w_index = BITREV ? bitrev3(r_rd_idx) : r_rd_idx;

   fft_round_shift #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_round_re (
      .i_x    (r_bank_re[r_rd_bank][w_index]),
      .i_ifft (r_mode[r_rd_bank]),
      .o_y    (w_y_re)
   );

   fft_round_shift #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_round_im (
      .i_x    (r_bank_im[r_rd_bank][w_index]),
      .i_ifft (r_mode[r_rd_bank]),
      .o_y    (w_y_im)
   );

   assign out_valid = w_out_valid;
   assign out_real  = w_out_valid ? w_y_re : '0;
   assign out_imag  = w_out_valid ? w_y_im : '0;
   assign out_index = w_index;
   assign out_last  = w_out_valid & (r_rd_idx == 3'd7);
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Self-checking bench: natural-order and bit-reversed unloaders against a beat-queue model.
module tb_fft_result_unloader;

   localparam int W = 32;

   typedef struct packed {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
      logic [2:0]          idx;
      logic                last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, strobe_a, strobe_b, ready_a, ready_b, ifft_mode, ovf_clr;
   logic signed [W-1:0] din_re [8];
   logic signed [W-1:0] din_im [8];

   logic val_a, last_a, ovf_a, val_b, last_b, ovf_b;
   logic signed [W-1:0] re_a, im_a, re_b, im_b;
   logic [2:0] idx_a, idx_b;

   int n_cmp = 0;
   int n_err = 0;

   beat_t exp_q [2][32];
   int    head  [2];
   int    cnt   [2];
   bit    m_ovf [2];
   beat_t log_q [2][128];
   int    log_n [2];
   int    br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_result_unloader #(.DATA_W(W), .FRAC_BITS(8), .BITREV(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .butterfly3_ready(strobe_a),
      .fft_d1_real_o(din_re[0]), .fft_d1_imag_o(din_im[0]),
      .fft_d2_real_o(din_re[1]), .fft_d2_imag_o(din_im[1]),
      .fft_d3_real_o(din_re[2]), .fft_d3_imag_o(din_im[2]),
      .fft_d4_real_o(din_re[3]), .fft_d4_imag_o(din_im[3]),
      .fft_d5_real_o(din_re[4]), .fft_d5_imag_o(din_im[4]),
      .fft_d6_real_o(din_re[5]), .fft_d6_imag_o(din_im[5]),
      .fft_d7_real_o(din_re[6]), .fft_d7_imag_o(din_im[6]),
      .fft_d8_real_o(din_re[7]), .fft_d8_imag_o(din_im[7]),
      .ifft_mode(ifft_mode), .out_valid(val_a), .out_ready(ready_a),
      .out_real(re_a), .out_imag(im_a), .out_index(idx_a), .out_last(last_a),
      .overflow(ovf_a), .overflow_clr(ovf_clr)
   );

   fft_result_unloader #(.DATA_W(W), .FRAC_BITS(8), .BITREV(1'b1)) dut_b (
      .clk(clk), .rst(rst_b), .butterfly3_ready(strobe_b),
      .fft_d1_real_o(din_re[0]), .fft_d1_imag_o(din_im[0]),
      .fft_d2_real_o(din_re[1]), .fft_d2_imag_o(din_im[1]),
      .fft_d3_real_o(din_re[2]), .fft_d3_imag_o(din_im[2]),
      .fft_d4_real_o(din_re[3]), .fft_d4_imag_o(din_im[3]),
      .fft_d5_real_o(din_re[4]), .fft_d5_imag_o(din_im[4]),
      .fft_d6_real_o(din_re[5]), .fft_d6_imag_o(din_im[5]),
      .fft_d7_real_o(din_re[6]), .fft_d7_imag_o(din_im[6]),
      .fft_d8_real_o(din_re[7]), .fft_d8_imag_o(din_im[7]),
      .ifft_mode(ifft_mode), .out_valid(val_b), .out_ready(ready_b),
      .out_real(re_b), .out_imag(im_b), .out_index(idx_b), .out_last(last_b),
      .overflow(ovf_b), .overflow_clr(ovf_clr)
   );

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Divide by 2^sh rounding half up (floor of x/2^sh + 1/2).
   function automatic logic signed [W-1:0] rescale(input logic signed [W-1:0] x, input logic m);
      longint v;
      int     sh;
      sh = m ? 11 : 8;
      v  = longint'(x) + (longint'(1) << (sh - 1));
      return W'(v >>> sh);
   endfunction

   task automatic push_frame(input int i);
      beat_t b;
      int    s;
      for (int k = 0; k < 8; k++) begin
         s      = (i == 1) ? br_tab[k] : k;
         b.re   = rescale(din_re[s], ifft_mode);
         b.im   = rescale(din_im[s], ifft_mode);
         b.idx  = 3'(s);
         b.last = (k == 7);
         exp_q[i][(head[i] + cnt[i]) % 32] = b;
         cnt[i]++;
      end
   endtask

   task automatic model_step(input int i, input logic stb, input logic rdy);
      bit pop_last, accept;
      int held;
      pop_last = rdy && cnt[i] > 0 && exp_q[i][head[i]].last;
      held     = (cnt[i] + 7) / 8;
      accept   = (held < 2) || pop_last;
      if (rdy && cnt[i] > 0) begin
         head[i] = (head[i] + 1) % 32;
         cnt[i]--;
      end
      if (stb && accept) push_frame(i);
      if (stb && !accept) m_ovf[i] = 1'b1;
      else if (ovf_clr)   m_ovf[i] = 1'b0;
   endtask

   task automatic model_clear(input int i);
      head[i]  = 0;
      cnt[i]   = 0;
      m_ovf[i] = 1'b0;
   endtask

   // Resets are only ever raised while clk is low, so clk==1 identifies a clock edge.
   always @(posedge clk or posedge rst_a or posedge rst_b) begin
      if (rst_a) model_clear(0);
      else if (clk) model_step(0, strobe_a, ready_a);
      if (rst_b) model_clear(1);
      else if (clk) model_step(1, strobe_b, ready_b);
   end

   task automatic compare(input int i, input logic v, input logic signed [W-1:0] re,
                          input logic signed [W-1:0] im, input logic [2:0] idx,
                          input logic last, input logic ovf, input logic rdy);
      beat_t e;
      beat_t got;
      check($sformatf("valid%0d", i), v, cnt[i] > 0);
      if (v && cnt[i] > 0) begin
         e = exp_q[i][head[i]];
         check($sformatf("real%0d", i), re, e.re);
         check($sformatf("imag%0d", i), im, e.im);
         check($sformatf("index%0d", i), idx, e.idx);
         check($sformatf("last%0d", i), last, e.last);
      end
      check($sformatf("overflow%0d", i), ovf, m_ovf[i]);
      if (v && rdy) begin
         got = '{re: re, im: im, idx: idx, last: last};
         log_q[i][log_n[i] % 128] = got;
         log_n[i]++;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         compare(0, val_a, re_a, im_a, idx_a, last_a, ovf_a, ready_a);
         compare(1, val_b, re_b, im_b, idx_b, last_b, ovf_b, ready_b);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe_a_once(input logic m);
      ifft_mode = m;
      strobe_a  = 1'b1;
      @(negedge clk);
      strobe_a  = 1'b0;
   endtask

   task automatic load_ramp(input int base);
      for (int k = 0; k < 8; k++) begin
         din_re[k] = 256 * (base + k);
         din_im[k] = -256 * (base + k);
      end
   endtask

   function automatic beat_t logged(input int i, input int n);
      return log_q[i][n % 128];
   endfunction

   initial begin
      int    base;
      bit    found;
      logic  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int    in_re [8] = '{128, 127, -128, -129, 383, -385, 0, 32'sh7FFFFFFF};
      int    if_im [8] = '{1024, 1023, -1024, -1025, 2047, -2048, 3072, 0};

      rst_a = 1'b1; rst_b = 1'b1; strobe_a = 1'b0; strobe_b = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1; ifft_mode = 1'b0; ovf_clr = 1'b0;
      load_ramp(1);
      tick(3);
      rst_a = 1'b0; rst_b = 1'b0;
      #3;
      check("rst_valid", val_a, 1'b0);
      check("rst_real", re_a, 0);
      check("rst_imag", im_a, 0);
      check("rst_index", idx_a, 0);
      check("rst_last", last_a, 1'b0);
      check("rst_overflow", ovf_a, 1'b0);

      // Single frame: real 1..8, imag -1..-8, first beat one cycle after the strobe.
      tick(1);
      base = log_n[0];
      strobe_a_once(1'b0);
      #3;
      check("first_valid", val_a, 1'b1);
      check("first_real", re_a, 1);
      check("first_imag", im_a, -1);
      tick(10);
      check("f1_beats", log_n[0] - base, 8);
      check("f1_b3_imag", logged(0, base + 3).im, -4);
      check("f1_b3_index", logged(0, base + 3).idx, 3);
      check("f1_b7_real", logged(0, base + 7).re, 8);
      check("f1_b7_last", logged(0, base + 7).last, 1'b1);
      check("f1_b6_last", logged(0, base + 6).last, 1'b0);

      // Rounding, FFT scaling.
      for (int k = 0; k < 8; k++) begin
         din_re[k] = in_re[k];
         din_im[k] = 256 * k - 512;
      end
      base = log_n[0];
      strobe_a_once(1'b0);
      tick(10);
      check("rnd_128", logged(0, base + 0).re, 1);
      check("rnd_127", logged(0, base + 1).re, 0);
      check("rnd_m128", logged(0, base + 2).re, 0);
      check("rnd_m129", logged(0, base + 3).re, -1);
      check("rnd_m385", logged(0, base + 5).re, -2);
      check("rnd_max", logged(0, base + 7).re, 8388608);

      // Rounding with IFFT normalisation.
      for (int k = 0; k < 8; k++) begin
         din_re[k] = 2048 * (k + 1);
         din_im[k] = if_im[k];
      end
      base = log_n[0];
      strobe_a_once(1'b1);
      tick(10);
      check("ifft_re0", logged(0, base + 0).re, 1);
      check("ifft_re7", logged(0, base + 7).re, 8);
      check("ifft_1024", logged(0, base + 0).im, 1);
      check("ifft_1023", logged(0, base + 1).im, 0);
      check("ifft_m1025", logged(0, base + 3).im, -1);

      // Backpressure with ready pattern 1,0,0,1.
      load_ramp(10);
      base = log_n[0];
      strobe_a_once(1'b0);
      for (int c = 0; c < 40; c++) begin
         ready_a = pat[c % 4];
         tick(1);
      end
      ready_a = 1'b1;
      tick(2);
      check("bp_beats", log_n[0] - base, 8);
      for (int j = 0; j < 8; j++)
         check($sformatf("bp_real%0d", j), logged(0, base + j).re, 10 + j);

      // Three strobes with the consumer stalled: third frame dropped.
      ready_a = 1'b0;
      base = log_n[0];
      for (int f = 0; f < 3; f++) begin
         load_ramp(20 + 10 * f);
         strobe_a_once(1'b0);
         tick(1);
      end
      #3;
      check("ovf_set", ovf_a, 1'b1);
      tick(1);
      ready_a = 1'b1;
      tick(22);
      check("ovf_beats", log_n[0] - base, 16);
      check("ovf_frame0", logged(0, base + 0).re, 20);
      check("ovf_frame1", logged(0, base + 8).re, 30);
      check("ovf_still", ovf_a, 1'b1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      #3;
      check("ovf_clr", ovf_a, 1'b0);

      // Strobe coincident with final pop while both banks full.
      tick(1);
      ready_a = 1'b0;
      base = log_n[0];
      load_ramp(50);
      strobe_a_once(1'b0);
      tick(1);
      load_ramp(60);
      strobe_a_once(1'b0);
      tick(1);
      ready_a = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (val_a && last_a) begin
            found = 1'b1;
            load_ramp(70);
            strobe_a = 1'b1;
            @(negedge clk);
            strobe_a = 1'b0;
         end
      end
      check("coinc_found", found, 1'b1);
      tick(30);
      check("coinc_beats", log_n[0] - base, 24);
      check("coinc_frame2", logged(0, base + 16).re, 70);
      check("coinc_last", logged(0, base + 23).last, 1'b1);
      check("coinc_ovf", ovf_a, 1'b0);

      // Bit-reversed order, then reset in the middle of the stream.
      load_ramp(1);
      base = log_n[1];
      strobe_b = 1'b1;
      tick(1);
      strobe_b = 1'b0;
      tick(3);
      check("br_b3_index", idx_b, 6);
      check("br_b3_real", re_b, 7);
      rst_b = 1'b1;
      #1;
      check("br_rst_valid", val_b, 1'b0);
      tick(3);
      rst_b = 1'b0;
      tick(6);
      check("br_beats", log_n[1] - base, 3);
      check("br_idx1", logged(1, base + 1).idx, 4);
      check("br_idx2", logged(1, base + 2).idx, 2);
      check("br_real1", logged(1, base + 1).re, 5);
      check("br_imag2", logged(1, base + 2).im, -3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_result_unloader.md
# fft_result_unloader

Receive-side sink for the 8-point FFT/IFFT datapath: captures each 8-sample complex frame presented in parallel by the final butterfly stage on its one-cycle ready strobe. It removes the stage's Q8 scaling with round-half-up, optionally applies the IFFT 1/N normalisation, and buffers the frame in a two-bank ping-pong store. It then streams the frame one complex sample per cycle over a valid/ready interface to the RISC-V load/store side.

## Interface
- DATA_W, default `instWidth (32): width of every real/imag component, in and out
- FRAC_BITS, default 8: fractional bits removed from butterfly output (Q8 twiddles)
- BITREV, default 0: 1 = emit samples in bit-reversed index order; 0 = natural order
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- butterfly3_ready  in  1  one-cycle frame strobe; no backpressure possible upstream
- fft_dK_real_o / fft_dK_imag_o, K=1..8  in  DATA_W each  frame sample K-1 (X[K-1]), two's complement, Q8-scaled
- ifft_mode  in  1  sampled with the strobe; 1 = additionally divide by 8 (arithmetic shift 3)
- out_valid  out  1  out_real/out_imag/out_index/out_last valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- out_real, out_imag  out  DATA_W  rescaled sample
- out_index  out  3  frequency/time index of the sample
- out_last  out  1  high on the 8th beat of a frame
- overflow  out  1  sticky: a frame was dropped because both banks were full
- overflow_clr  in  1  synchronous clear of overflow

## Operation
- Storage: two banks × 8 complex words plus per-bank full flag and per-bank ifft_mode bit; write pointer wr_bank, read pointer rd_bank, beat counter rd_idx (0..7).
- Capture: on strobe, if bank[wr_bank] not full (or is being freed this cycle by the last pop), store all 16 inputs raw, latch ifft_mode, set full, toggle wr_bank. Otherwise drop the frame, set overflow; pointers unchanged.
- Rescale applied on output path: y = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed in DATA_W+1 bits, so +max input does not wrap. If bank mode bit = 1, shift is FRAC_BITS+3 with rounding constant 2^(FRAC_BITS+2). Result sign-extended/truncated to DATA_W (always fits).
- FSM per read side: IDLE (rd bank empty, out_valid=0) → STREAM when bank[rd_bank] full. STREAM: out_valid=1; on handshake rd_idx++; on handshake with rd_idx=7: clear full, toggle rd_bank, rd_idx=0, stay STREAM if other bank full else IDLE.
- out_index = rd_idx if BITREV=0, else bitrev3(rd_idx); data word read = sample[out_index].
- out_last = out_valid & (rd_idx==7).
- Outputs hold stable while out_valid & !out_ready.
- overflow_clr and a simultaneous drop in the same cycle: overflow ends 1 (set wins).

## Timing
- Reset (async assert): out_valid=0, out_real=out_imag=0, out_index=0, out_last=0, overflow=0, both banks empty, wr_bank=rd_bank=0, rd_idx=0. Stored data not cleared.
- Latency: strobe sampled at edge N → out_valid high after edge N (first beat visible in cycle N+1), combinational rescale from registered bank.
- Throughput: 1 beat/cycle; back-to-back frames stream with no bubble between beat 7 and next beat 0.
- Strobe in same cycle as final pop of the only full bank when both full: frame accepted into freed bank, no overflow.
- Reset mid-frame discards partial stream; no out_last emitted for it.

## Structure
- Shared package/`define.v: `instWidth, FRAC_BITS constant, `funEnable/`funDisable, state encodings IDLE/STREAM.
- Sub-module fft_round_shift (DATA_W, shift param via mode input): rounding arithmetic shift, instantiated twice (real, imag).

## Test plan
- Single frame, all dK_real=256·K, imag=−256·K, ifft_mode=0, out_ready=1 → 8 beats real=1..8, imag=−1..−8, index 0..7, out_last on beat 8, first valid one cycle after strobe.
- Rounding: inputs 128, 127, −128, −129 → outputs 1, 0, 0, −1; with ifft_mode=1 and input 2048·K → K (e.g. 2048→1, 1024→1, 1023→0).
- Backpressure: out_ready toggled 1,0,0,1… → no beat lost or duplicated, outputs stable while stalled.
- Three strobes 1 cycle apart with out_ready=0 → first two stored, third dropped, overflow=1; release → exactly 16 beats; overflow_clr → 0.
- Strobe coincident with last pop while both banks full → accepted, overflow stays 0, 24 total beats.
- BITREV=1 → out_index sequence 0,4,2,6,1,5,3,7 with matching data; reset asserted at beat 3 → out_valid=0 immediately, no further beats.
